char_uart_tx: RTL

- Sits directly downstream of the receiver top level.
- Consumes the decoded ASCII stream (char_out/char_valid), buffers characters in a small FIFO and serialises them on an 8N1 UART line for host logging.
- Decouples the bursty varicode decoder output from the fixed-rate serial link and reports overflow when the host link cannot keep up.

---
 rtl/char_uart_tx_if.sv | 16 +
 rtl/char_uart_tx.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/char_uart_tx_if.sv
// -----------------------------------------------------------------------------
// char_uart_tx_if
// Character stream from the varicode decoder into the UART logger.
//   char_in    : 8-bit ASCII character, valid only while char_valid is high
//   char_valid : single-cycle strobe qualifying char_in
// Modports:
//   master : the decoder side, drives the stream
//   slave  : the UART transmitter side, consumes the stream
// -----------------------------------------------------------------------------
interface char_uart_tx_if;
  logic [7:0] char_in;
  logic       char_valid;

  modport master (output char_in, output char_valid);
  modport slave  (input  char_in, input  char_valid);
endinterface

// File: rtl/char_uart_tx.sv
// -----------------------------------------------------------------------------
// char_uart_tx
// Buffers the decoded ASCII stream in a small FIFO and serialises it onto an
// 8N1 UART line (8E1 when CHAR_UART_PARITY_EN is defined) for host logging.
// A sticky overflow flag reports characters dropped because the FIFO was full.
//
// Build option:
//   CHAR_UART_PARITY_EN : adds an even-parity bit after the data bits.
//
// Ports:
//   clk        : system clock
//   rst        : synchronous, active-low reset
//   en         : allows new frames to start (a running frame always finishes)
//   char_if    : character stream (char_in / char_valid), slave side
//   ovf_clr    : clears the sticky overflow flag
//   uart_tx    : serial line, idles high
//   tx_busy    : high from start bit through stop bit
//   fifo_count : number of characters held in the FIFO
//   overflow   : sticky, set when a character is dropped
// -----------------------------------------------------------------------------
module char_uart_tx #(
  parameter int SYS_CLK_FREQ = 6400000,
  parameter int BAUD_RATE    = 115200,
  parameter int DEPTH        = 16,
  parameter int AW           = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  char_uart_tx_if.slave  char_if,
  input  logic           ovf_clr,
  output logic           uart_tx,
  output logic           tx_busy,
  output logic [AW:0]    fifo_count,
  output logic           overflow
);

  localparam int CLKS_PER_BIT = SYS_CLK_FREQ / BAUD_RATE;
  localparam int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
  localparam logic [AW:0]   DEPTH_V   = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef CHAR_UART_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd3
  } state_t;

`ifdef CHAR_UART_PARITY_EN
  // Even parity: the bit that makes the total number of ones even.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`endif

  // FIFO storage and bookkeeping
  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          ovf_r;

  // Transmitter state
  state_t        state_r;
  state_t        state_nxt_s;
  logic [CW-1:0] baud_cnt_r;
  logic [CW-1:0] baud_nxt_s;
  logic [2:0]    bit_idx_r;
  logic [2:0]    bit_idx_nxt_s;
  logic [7:0]    shift_r;
  logic [7:0]    shift_nxt_s;
  logic          tx_r;
  logic          tx_nxt_s;
  logic          busy_r;
  logic          busy_nxt_s;

  logic          pop_s;
  logic          push_s;
  logic          drop_s;
  logic          bit_end_s;
  logic [7:0]    rd_data_s;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then.
  assign pop_s     = (state_r == IDLE) && en && (count_r != {(AW + 1){1'b0}});
  assign push_s    = char_if.char_valid && ((count_r != DEPTH_V) || pop_s);
  assign drop_s    = char_if.char_valid && !push_s;
  assign bit_end_s = (baud_cnt_r == BAUD_LAST);
  assign rd_data_s = mem_r[rd_ptr_r];

  // FIFO data array write port; contents need no reset because pointers do.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= char_if.char_in;
    end
  end

  // FIFO pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW + 1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky overflow flag; a drop wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf_r <= 1'b0;
    end else if (drop_s) begin
      ovf_r <= 1'b1;
    end else if (ovf_clr) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  // Transmitter state register plus registered line and busy outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= IDLE;
      baud_cnt_r <= {CW{1'b0}};
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'h00;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      baud_cnt_r <= baud_nxt_s;
      bit_idx_r  <= bit_idx_nxt_s;
      shift_r    <= shift_nxt_s;
      tx_r       <= tx_nxt_s;
      busy_r     <= busy_nxt_s;
    end
  end

  // Next-state logic: each bit lasts CLKS_PER_BIT cycles counted by baud_cnt_r.
  always_comb begin
    state_nxt_s   = state_r;
    baud_nxt_s    = baud_cnt_r;
    bit_idx_nxt_s = bit_idx_r;
    shift_nxt_s   = shift_r;
    case (state_r)
      IDLE: begin
        baud_nxt_s    = {CW{1'b0}};
        bit_idx_nxt_s = 3'd0;
        if (pop_s) begin
          state_nxt_s = START;
          shift_nxt_s = rd_data_s;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_nxt_s = DATA;
          baud_nxt_s  = {CW{1'b0}};
        end else begin
          baud_nxt_s  = baud_cnt_r + BAUD_ONE;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          baud_nxt_s = {CW{1'b0}};
          if (bit_idx_r == 3'd7) begin
            bit_idx_nxt_s = 3'd0;
`ifdef CHAR_UART_PARITY_EN
            state_nxt_s   = PARITY;
`else
            state_nxt_s   = STOP;
`endif
          end else begin
            bit_idx_nxt_s = bit_idx_r + 3'd1;
          end
        end else begin
          baud_nxt_s = baud_cnt_r + BAUD_ONE;
        end
      end
`ifdef CHAR_UART_PARITY_EN
      PARITY: begin
        if (bit_end_s) begin
          state_nxt_s = STOP;
          baud_nxt_s  = {CW{1'b0}};
        end else begin
          baud_nxt_s  = baud_cnt_r + BAUD_ONE;
        end
      end
`endif
      STOP: begin
        if (bit_end_s) begin
          state_nxt_s = IDLE;
          baud_nxt_s  = {CW{1'b0}};
        end else begin
          baud_nxt_s  = baud_cnt_r + BAUD_ONE;
        end
      end
      default: begin
        state_nxt_s   = IDLE;
        baud_nxt_s    = {CW{1'b0}};
        bit_idx_nxt_s = 3'd0;
      end
    endcase
  end

  // Line level is decoded from the next state so uart_tx can be a flop
  // that changes in step with state_r.
  always_comb begin
    tx_nxt_s   = 1'b1;
    busy_nxt_s = 1'b0;
    case (state_nxt_s)
      IDLE: begin
        tx_nxt_s   = 1'b1;
        busy_nxt_s = 1'b0;
      end
      START: begin
        tx_nxt_s   = 1'b0;
        busy_nxt_s = 1'b1;
      end
      DATA: begin
        tx_nxt_s   = shift_nxt_s[bit_idx_nxt_s];
        busy_nxt_s = 1'b1;
      end
`ifdef CHAR_UART_PARITY_EN
      PARITY: begin
        tx_nxt_s   = even_parity(shift_nxt_s);
        busy_nxt_s = 1'b1;
      end
`endif
      STOP: begin
        tx_nxt_s   = 1'b1;
        busy_nxt_s = 1'b1;
      end
      default: begin
        tx_nxt_s   = 1'b1;
        busy_nxt_s = 1'b0;
      end
    endcase
  end

  assign uart_tx    = tx_r;
  assign tx_busy    = busy_r;
  assign fifo_count = count_r;
  assign overflow   = ovf_r;

endmodule
